// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU controller slice.
//   opcode_e      : instruction opcodes
//   state_e       : controller FSM states
//   *Ofs          : instruction field offsets, counted down from the instruction MSB
//   instr_width() : instruction width for a given immediate width
package tpu_pkg;

  typedef enum logic [1:0] {
    OpNop   = 2'b00,
    OpRun   = 2'b01,
    OpLoad  = 2'b10,
    OpStore = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    StIdle,
    StFeed,
    StDrain,
    StDone
  } state_e;

  // Header layout, MSB first: opcode(2) sel(1) rsvd(1) row(4) col(4), then imm in the low bits.
  // The header is 12 bits so that col and imm stay disjoint.
  localparam int unsigned OpcodeOfs = 0;
  localparam int unsigned SelOfs    = 2;
  localparam int unsigned RsvdOfs   = 3;
  localparam int unsigned RowOfs    = 4;
  localparam int unsigned ColOfs    = 8;
  localparam int unsigned FieldW    = 4;
  localparam int unsigned HdrW      = 12;

  function automatic int unsigned instr_width(int unsigned data_width);
    return HdrW + data_width;
  endfunction

endpackage

// File: rtl/tpu_controller_if.sv
// Instruction handshake between an issuer (master) and the controller (slave).
//   instr_valid : instruction present (master -> slave)
//   instruction : encoded instruction (master -> slave)
//   instr_ready : controller can accept this cycle (slave -> master)
interface tpu_controller_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  import tpu_pkg::*;

  localparam int unsigned INSTR_W = instr_width(DATA_WIDTH);

  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instruction;

  modport master (
    output instr_valid,
    output instruction,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instruction,
    output instr_ready
  );

endinterface

// File: rtl/tpu_skew_gen.sv
// Skewed read-enable generator for an N x N systolic array.
//   counter     : feed counter (1..2N-1 while feeding)
//   read_enable : line i enabled when i < counter <= i+N
//   read_elem   : element index counter-1-i for enabled lines, else 0;
//                 line i at [i*IDX_W +: IDX_W]
module tpu_skew_gen #(
  parameter int unsigned N = 4
) (
  input  logic [$clog2(3*N)-1:0]  counter,
  output logic [N-1:0]            read_enable,
  output logic [N*$clog2(N)-1:0]  read_elem
);

  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned CNT_W = $clog2(3*N);

  for (genvar gi = 0; gi < N; gi++) begin : g_line
    logic [IDX_W-1:0] elem_idx;

    assign read_enable[gi] = (counter > CNT_W'(gi)) && (counter <= CNT_W'(gi + N));
    // Only meaningful when enabled, where the difference is 0..N-1.
    assign elem_idx = IDX_W'(counter - CNT_W'(gi + 1));
    assign read_elem[gi*IDX_W +: IDX_W] = read_enable[gi] ? elem_idx : '0;
  end

endmodule

// File: rtl/tpu_controller.sv
// Instruction sequencer for an N x N systolic array.
//   clk, rst             : clock, synchronous active-high reset
//   ibus                 : instruction handshake (slave side)
//   mem{a,b}_write_enable: LOAD strobes; mem_write_line/elem/data_in carry the target and data
//   mem{a,b}_read_enable : per-line skewed read enables (A and B identical)
//   mem{a,b}_read_elem   : per-line element index
//   array_write_enable   : array compute enable (FEED and DRAIN)
//   array_clear          : accumulator clear, first FEED cycle of a clear-mode RUN
//   array_output_row/col : STORE select, store_valid qualifies it
//   busy, done           : RUN in progress, one-cycle RUN-complete pulse
module tpu_controller
  import tpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned N          = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  tpu_controller_if.slave            ibus,
  output logic                       mema_write_enable,
  output logic                       memb_write_enable,
  output logic [$clog2(N)-1:0]       mem_write_line,
  output logic [$clog2(N)-1:0]       mem_write_elem,
  output logic [DATA_WIDTH-1:0]      mem_data_in,
  output logic [N-1:0]               mema_read_enable,
  output logic [N-1:0]               memb_read_enable,
  output logic [N*$clog2(N)-1:0]     mema_read_elem,
  output logic [N*$clog2(N)-1:0]     memb_read_elem,
  output logic                       array_write_enable,
  output logic                       array_clear,
  output logic [$clog2(N)-1:0]       array_output_row,
  output logic [$clog2(N)-1:0]       array_output_col,
  output logic                       store_valid,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned IDX_W   = $clog2(N);
  localparam int unsigned INSTR_W = instr_width(DATA_WIDTH);
  localparam int unsigned CNT_W   = $clog2(3*N);

  localparam logic [CNT_W-1:0] FeedLast  = CNT_W'(2*N - 1);
  localparam logic [CNT_W-1:0] DrainLast = CNT_W'(3*N - 2);

  state_e           state;
  logic [CNT_W-1:0] counter;

  // Instruction field decode
  opcode_e         op;
  logic            sel;
  logic [FieldW-1:0] row_f;
  logic [FieldW-1:0] col_f;
  logic [DATA_WIDTH-1:0] imm;
  logic            ready;
  logic            accept;
  logic            unused_instr;

  assign op    = opcode_e'(ibus.instruction[INSTR_W-1-OpcodeOfs -: 2]);
  assign sel   = ibus.instruction[INSTR_W-1-SelOfs];
  assign row_f = ibus.instruction[INSTR_W-1-RowOfs -: FieldW];
  assign col_f = ibus.instruction[INSTR_W-1-ColOfs -: FieldW];
  assign imm   = ibus.instruction[DATA_WIDTH-1:0];

  // rsvd and the row/col bits above IDX_W carry no meaning
  assign unused_instr = ^{ibus.instruction[INSTR_W-1-RsvdOfs], row_f, col_f};

  // Held low during reset so nothing is accepted on a reset edge.
  assign ready            = (state == StIdle) && !rst;
  assign ibus.instr_ready = ready;
  assign accept           = ibus.instr_valid && ready;

  // LOAD / STORE act in the accept cycle only.
  always_comb begin
    mema_write_enable = 1'b0;
    memb_write_enable = 1'b0;
    mem_write_line    = '0;
    mem_write_elem    = '0;
    mem_data_in       = '0;
    store_valid       = 1'b0;
    array_output_row  = '0;
    array_output_col  = '0;
    if (accept) begin
      case (op)
        OpLoad: begin
          mema_write_enable = !sel;
          memb_write_enable = sel;
          mem_write_line    = row_f[IDX_W-1:0];
          mem_write_elem    = col_f[IDX_W-1:0];
          mem_data_in       = imm;
        end
        OpStore: begin
          store_valid      = 1'b1;
          array_output_row = row_f[IDX_W-1:0];
          array_output_col = col_f[IDX_W-1:0];
        end
        default: ;
      endcase
    end
  end

  // RUN sequencing: FEED counts 1..2N-1, DRAIN continues 2N..3N-2, DONE is one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= StIdle;
      counter            <= '0;
      array_write_enable <= 1'b0;
      array_clear        <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
    end else begin
      array_clear <= 1'b0;
      done        <= 1'b0;
      unique case (state)
        StIdle: begin
          if (accept && (op == OpRun)) begin
            state              <= StFeed;
            counter            <= CNT_W'(1);
            array_write_enable <= 1'b1;
            array_clear        <= !sel;
            busy               <= 1'b1;
          end
        end
        StFeed: begin
          counter <= counter + CNT_W'(1);
          if (counter == FeedLast) begin
            state <= StDrain;
          end
        end
        StDrain: begin
          if (counter == DrainLast) begin
            state              <= StDone;
            array_write_enable <= 1'b0;
            done               <= 1'b1;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        StDone: begin
          state   <= StIdle;
          counter <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  logic [N-1:0]       skew_en;
  logic [N*IDX_W-1:0] skew_elem;
  logic               feeding;

  tpu_skew_gen #(
    .N (N)
  ) u_skew_gen (
    .counter     (counter),
    .read_enable (skew_en),
    .read_elem   (skew_elem)
  );

  assign feeding          = (state == StFeed);
  assign mema_read_enable = feeding ? skew_en : '0;
  assign memb_read_enable = feeding ? skew_en : '0;
  assign mema_read_elem   = feeding ? skew_elem : '0;
  assign memb_read_elem   = feeding ? skew_elem : '0;

endmodule
